// File: rtl/mem_port_ctrl_pkg.sv
// Shared RV32/RV64 types for the MEM stage data-memory port.
// Holds the port FSM state type and the load/store funct3 codes.
package rv32i_types;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } mem_port_state_t;

  localparam logic [2:0] load_f3_lb  = 3'b000;
  localparam logic [2:0] load_f3_lh  = 3'b001;
  localparam logic [2:0] load_f3_lw  = 3'b010;
  localparam logic [2:0] load_f3_ld  = 3'b011;
  localparam logic [2:0] load_f3_lbu = 3'b100;
  localparam logic [2:0] load_f3_lhu = 3'b101;
  localparam logic [2:0] load_f3_lwu = 3'b110;

  localparam logic [2:0] store_f3_sb = 3'b000;
  localparam logic [2:0] store_f3_sh = 3'b001;
  localparam logic [2:0] store_f3_sw = 3'b010;
  localparam logic [2:0] store_f3_sd = 3'b011;

  // Byte-lane pattern for an access of size 1<<sz, before lane shift.
  function automatic logic [7:0] size_mask(logic [1:0] sz);
    unique case (sz)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_ctrl_load_align.sv
// Load data alignment: shifts the addressed lane down and extends it.
// Ports: rdata (raw dmem word), ofs (byte offset), funct3 -> data (extended).
module mem_load_align
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  localparam int OFS = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [OFS-1:0]    ofs,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] sh;

  assign sh = rdata >> {ofs, 3'b000};

  always_comb begin
    data = '0;
    unique case (funct3)
      load_f3_lb:  data = DATA_W'($signed(sh[7:0]));
      load_f3_lh:  data = DATA_W'($signed(sh[15:0]));
      load_f3_lw:  data = DATA_W'($signed(sh[31:0]));
      load_f3_lbu: data = DATA_W'(sh[7:0]);
      load_f3_lhu: data = DATA_W'(sh[15:0]);
      load_f3_lwu: data = DATA_W'(sh[31:0]);
      load_f3_ld:  data = sh;
      default:     data = '0;
    endcase
  end

endmodule

// File: rtl/mem_port_ctrl.sv
// MEM-stage data-memory port: one load/store per handshake, lane-masked
// single-cycle dmem request, variable-latency response, held result.
// Ports: req_* (op in, req_ready stall), dmem_* (memory side),
// rsp_* (held result: rsp_valid/rsp_ready, rsp_rdata, rsp_err).
module mem_port_ctrl
  import rv32i_types::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OFS = $clog2(NB)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_re,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [NB-1:0]     dmem_rmask,
  output logic [NB-1:0]     dmem_wmask,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  mem_port_state_t state, state_nx;

  logic              op_we, op_re, err_q, req_err;
  logic [2:0]        op_f3;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_wdata, rdata_q, ext, wsized;
  logic [OFS-1:0]    ofs;
  logic [NB-1:0]     lane;
  logic              accept, capture, issue, done;

  assign issue   = (state == ST_ISSUE);
  assign done    = (state == ST_DONE);
  assign req_ready = (state == ST_IDLE) || (done && rsp_ready);
  assign accept  = req_valid && req_ready;
  assign capture = dmem_resp && (issue || (state == ST_WAIT));
  assign ofs     = op_addr[OFS-1:0];

  // Width legality first, then natural alignment by size.
  always_comb begin
    req_err = 1'b0;
    if (req_we) begin
      unique case (req_funct3)
        store_f3_sb, store_f3_sh, store_f3_sw: req_err = 1'b0;
        store_f3_sd: req_err = (DATA_W == 32);
        default:     req_err = 1'b1;
      endcase
    end else if (req_re) begin
      unique case (req_funct3)
        load_f3_lb, load_f3_lh, load_f3_lw,
        load_f3_lbu, load_f3_lhu: req_err = 1'b0;
        load_f3_ld, load_f3_lwu:  req_err = (DATA_W == 32);
        default:                  req_err = 1'b1;
      endcase
    end else begin
      req_err = 1'b1;
    end
    unique case (req_funct3[1:0])
      2'b01:   req_err = req_err | req_addr[0];
      2'b10:   req_err = req_err | (|req_addr[1:0]);
      2'b11:   req_err = req_err | (|req_addr[2:0]);
      default: req_err = req_err;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nx = req_err ? ST_DONE : ST_ISSUE;
      ST_ISSUE: state_nx = capture ? ST_DONE : ST_WAIT;
      ST_WAIT:  if (capture) state_nx = ST_DONE;
      default: begin
        if (accept)         state_nx = req_err ? ST_DONE : ST_ISSUE;
        else if (rsp_ready) state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      op_we    <= 1'b0;
      op_re    <= 1'b0;
      op_f3    <= '0;
      op_addr  <= '0;
      op_wdata <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_we    <= req_we;
        op_re    <= req_re;
        op_f3    <= req_funct3;
        op_addr  <= req_addr;
        op_wdata <= req_wdata;
        err_q    <= req_err;
        rdata_q  <= '0;
      end else if (capture) begin
        rdata_q <= op_re ? ext : '0;
      end
    end
  end

  mem_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata  (dmem_rdata),
    .ofs    (ofs),
    .funct3 (op_f3),
    .data   (ext)
  );

  assign lane = NB'(size_mask(op_f3[1:0])) << ofs;

  always_comb begin
    wsized = '0;
    unique case (op_f3[1:0])
      2'd0:    wsized = DATA_W'(op_wdata[7:0]);
      2'd1:    wsized = DATA_W'(op_wdata[15:0]);
      2'd2:    wsized = DATA_W'(op_wdata[31:0]);
      default: wsized = op_wdata;
    endcase
  end

  assign dmem_addr  = issue ? {op_addr[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
  assign dmem_rmask = (issue && op_re) ? lane : '0;
  assign dmem_wmask = (issue && op_we) ? lane : '0;
  assign dmem_wdata = (issue && op_we) ? (wsized << {ofs, 3'b000}) : '0;

  assign rsp_valid = done;
  assign rsp_rdata = done ? rdata_q : '0;
  assign rsp_err   = done && err_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: a 32-bit and a 64-bit instance share stimulus,
// one is selected per op; results are compared against an arithmetic model.
module tb_mem_port_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bit          s = 1'b0;
  logic        vld = 1'b0, we = 1'b0, re = 1'b0;
  logic        rsp_ready = 1'b0, resp = 1'b0;
  logic [2:0]  f3 = '0;
  logic [31:0] addr = '0;
  logic [63:0] wdata = '0, rdata = '0;

  logic        a_req_ready, a_rsp_valid, a_rsp_err;
  logic [31:0] a_dmem_addr, a_dmem_wdata, a_rsp_rdata;
  logic [3:0]  a_rmask, a_wmask;
  logic        b_req_ready, b_rsp_valid, b_rsp_err;
  logic [31:0] b_dmem_addr;
  logic [63:0] b_dmem_wdata, b_rsp_rdata;
  logic [7:0]  b_rmask, b_wmask;

  logic        o_ready, o_rvalid, o_err;
  logic [31:0] o_daddr;
  logic [7:0]  o_rmask, o_wmask;
  logic [63:0] o_dwdata, o_rdata;

  int n_tests = 0;
  int n_fail = 0;

  mem_port_ctrl #(.DATA_W(32), .ADDR_W(32)) u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vld & ~s), .req_ready(a_req_ready),
    .req_we(we), .req_re(re), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata[31:0]),
    .dmem_addr(a_dmem_addr), .dmem_rmask(a_rmask),
    .dmem_wmask(a_wmask), .dmem_wdata(a_dmem_wdata),
    .dmem_rdata(rdata[31:0]), .dmem_resp(resp & ~s),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready & ~s),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
  );

  mem_port_ctrl #(.DATA_W(64), .ADDR_W(32)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(vld & s), .req_ready(b_req_ready),
    .req_we(we), .req_re(re), .req_funct3(f3),
    .req_addr(addr), .req_wdata(wdata),
    .dmem_addr(b_dmem_addr), .dmem_rmask(b_rmask),
    .dmem_wmask(b_wmask), .dmem_wdata(b_dmem_wdata),
    .dmem_rdata(rdata), .dmem_resp(resp & s),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready & s),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
  );

  always_comb begin
    if (s) begin
      o_ready  = b_req_ready;
      o_daddr  = b_dmem_addr;
      o_rmask  = b_rmask;
      o_wmask  = b_wmask;
      o_dwdata = b_dmem_wdata;
      o_rvalid = b_rsp_valid;
      o_rdata  = b_rsp_rdata;
      o_err    = b_rsp_err;
    end else begin
      o_ready  = a_req_ready;
      o_daddr  = a_dmem_addr;
      o_rmask  = {4'b0, a_rmask};
      o_wmask  = {4'b0, a_wmask};
      o_dwdata = {32'b0, a_dmem_wdata};
      o_rvalid = a_rsp_valid;
      o_rdata  = {32'b0, a_rsp_rdata};
      o_err    = a_rsp_err;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access of 2^f3[1:0] bytes at addr, lane offset addr mod NB.
  function automatic void model(
    input bit w64, input bit mwe, input bit mre,
    input logic [2:0] mf3, input logic [31:0] maddr,
    input logic [63:0] mwd, input logic [63:0] mrd,
    output bit e, output logic [31:0] da, output logic [7:0] mk,
    output logic [63:0] ewd, output logic [63:0] erd);
    int nb, sz, off;
    bit legal;
    logic [63:0] bits, v, rd;
    nb = w64 ? 8 : 4;
    sz = 1 << mf3[1:0];
    off = int'(maddr % nb);
    bits = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : (64'd1 << (8 * sz)) - 64'd1;
    if (mwe && !mre)
      legal = (mf3 inside {3'd0, 3'd1, 3'd2}) || (mf3 == 3'd3 && w64);
    else if (mre && !mwe)
      legal = (mf3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ||
              ((mf3 == 3'd3 || mf3 == 3'd6) && w64);
    else
      legal = 1'b0;
    e = !legal || (maddr % sz != 0);
    da = maddr - 32'(off);
    mk = 8'(((1 << sz) - 1) << off);
    ewd = mwe ? ((mwd & bits) << (8 * off)) : 64'd0;
    rd = w64 ? mrd : {32'b0, mrd[31:0]};
    v = (rd >> (8 * off)) & bits;
    if (!mf3[2] && sz < 8 && v[8 * sz - 1]) v = v | ~bits;
    if (!w64) v = {32'b0, v[31:0]};
    erd = (mre && !e) ? v : 64'd0;
  endfunction

  task automatic do_op(input bit sel, input bit owe, input bit ore,
                       input logic [2:0] of3, input logic [31:0] oad,
                       input logic [63:0] owd, input logic [63:0] ord,
                       input int k, input int hold,
                       output logic [63:0] got);
    bit e;
    logic [31:0] da;
    logic [7:0] mk;
    logic [63:0] ewd, erd;
    model(sel, owe, ore, of3, oad, owd, ord, e, da, mk, ewd, erd);
    @(negedge clk);
    s = sel; vld = 1'b1; we = owe; re = ore; f3 = of3;
    addr = oad; wdata = owd; rsp_ready = 1'b0; resp = 1'b0;
    #1;
    check("acc_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    vld = 1'b0;
    #1;
    if (e) begin
      check("err_valid", 64'(o_rvalid), 64'd1);
      check("err_flag", 64'(o_err), 64'd1);
      check("err_mask", 64'({o_rmask, o_wmask}), 64'd0);
    end else begin
      check("iss_addr", 64'(o_daddr), 64'(da));
      check("iss_rmask", 64'(o_rmask), ore ? 64'(mk) : 64'd0);
      check("iss_wmask", 64'(o_wmask), owe ? 64'(mk) : 64'd0);
      check("iss_wdata", o_dwdata, ewd);
      check("iss_valid", 64'(o_rvalid), 64'd0);
      rdata = ord;
      for (int i = 0; i < k; i++) begin
        resp = 1'b0;
        @(negedge clk);
        #1;
        check("wait_mask", 64'({o_rmask, o_wmask}), 64'd0);
        check("wait_valid", 64'(o_rvalid), 64'd0);
      end
      resp = 1'b1;
      @(negedge clk);
      resp = 1'b0;
      #1;
      check("done_valid", 64'(o_rvalid), 64'd1);
      check("done_err", 64'(o_err), 64'd0);
    end
    check("done_rdata", o_rdata, erd);
    got = o_rdata;
    for (int i = 0; i < hold; i++) begin
      rdata = {$urandom, $urandom};
      @(negedge clk);
      #1;
      check("hold_rdata", o_rdata, erd);
      check("hold_valid", 64'(o_rvalid), 64'd1);
      check("hold_ready", 64'(o_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("idle_valid", 64'(o_rvalid), 64'd0);
    check("idle_ready", 64'(o_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] got;
    logic [31:0] ra;
    logic [2:0]  rf;
    bit          rs, rwe, rre;
    int          kind;

    repeat (3) @(negedge clk);
    #1;
    check("rst_a_ready", 64'(a_req_ready), 64'd1);
    check("rst_b_ready", 64'(b_req_ready), 64'd1);
    check("rst_a_out", 64'(|{a_dmem_addr, a_rmask, a_wmask, a_dmem_wdata,
                              a_rsp_valid, a_rsp_rdata, a_rsp_err}), 64'd0);
    check("rst_b_out", 64'(|{b_dmem_addr, b_rmask, b_wmask, b_dmem_wdata,
                              b_rsp_valid, b_rsp_rdata, b_rsp_err}), 64'd0);
    rst_n = 1'b1;

    do_op(0, 1, 0, 3'b000, 32'h1003, 64'hAABBCCDD, 64'd0, 2, 0, got);
    do_op(0, 0, 1, 3'b001, 32'h2002, 64'd0, 64'h80011234, 1, 0, got);
    check("lh_value", got, 64'hFFFF8001);
    do_op(0, 0, 1, 3'b101, 32'h2002, 64'd0, 64'h80011234, 0, 0, got);
    check("lhu_value", got, 64'h00008001);
    do_op(0, 0, 1, 3'b010, 32'h2001, 64'd0, 64'd0, 0, 1, got);
    do_op(0, 0, 1, 3'b011, 32'h3000, 64'd0, 64'd0, 0, 0, got);
    do_op(1, 0, 1, 3'b011, 32'h3008, 64'd0, 64'h0123456789ABCDEF, 0, 0, got);
    check("ld_value", got, 64'h0123456789ABCDEF);
    do_op(1, 0, 1, 3'b110, 32'h300C, 64'd0, 64'h0123456789ABCDEF, 3, 0, got);
    check("lwu_value", got, 64'h0000000001234567);
    do_op(1, 1, 0, 3'b011, 32'h3010, 64'h1122334455667788, 64'd0, 1, 0, got);
    do_op(1, 0, 1, 3'b000, 32'h3017, 64'd0, 64'h80FFFFFFFFFFFFFF, 0, 0, got);
    check("lb64_value", got, 64'hFFFFFFFFFFFFFF80);
    do_op(0, 0, 1, 3'b010, 32'h4000, 64'd0, 64'hDEADBEEF, 1, 5, got);

    // Back-to-back: new op accepted in the DONE cycle it is released.
    do_op(0, 0, 1, 3'b010, 32'h2000, 64'd0, 64'h11223344, 0, 0, got);
    @(negedge clk);
    s = 1'b0; vld = 1'b1; we = 1'b0; re = 1'b1; f3 = 3'b010;
    addr = 32'h2000; rdata = 64'h11223344;
    @(negedge clk);
    vld = 1'b0; resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    #1;
    check("b2b_first", o_rdata, 64'h11223344);
    rsp_ready = 1'b1; vld = 1'b1; we = 1'b1; re = 1'b0;
    f3 = 3'b010; addr = 32'h2004; wdata = 64'hCAFEF00D;
    #1;
    check("b2b_ready", 64'(o_ready), 64'd1);
    @(negedge clk);
    vld = 1'b0; rsp_ready = 1'b0;
    #1;
    check("b2b_issue_wmask", 64'(o_wmask), 64'hF);
    check("b2b_issue_addr", 64'(o_daddr), 64'h2004);
    check("b2b_issue_wdata", o_dwdata, 64'hCAFEF00D);
    check("b2b_issue_valid", 64'(o_rvalid), 64'd0);
    resp = 1'b1;
    @(negedge clk);
    resp = 1'b0;
    #1;
    check("b2b_done_valid", 64'(o_rvalid), 64'd1);
    check("b2b_done_rdata", o_rdata, 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset while waiting, stale response afterwards.
    s = 1'b0; vld = 1'b1; we = 1'b0; re = 1'b1; f3 = 3'b010; addr = 32'h40;
    @(negedge clk);
    vld = 1'b0;
    #1;
    check("rw_issue_rmask", 64'(o_rmask), 64'hF);
    @(negedge clk);
    #1;
    check("rw_wait_rmask", 64'(o_rmask), 64'd0);
    rst_n = 1'b0; resp = 1'b1; rdata = 64'h5555AAAA;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check("rw_valid", 64'(o_rvalid), 64'd0);
      check("rw_mask", 64'({o_rmask, o_wmask}), 64'd0);
      check("rw_ready", 64'(o_ready), 64'd1);
    end
    resp = 1'b0;

    for (int n = 0; n < 60; n++) begin
      rs = 1'($urandom_range(0, 1));
      kind = $urandom_range(0, 9);
      rwe = (kind >= 5);
      rre = (kind >= 1 && kind < 5);
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      if ($urandom_range(0, 3) != 0)
        ra = ra & ~((32'd1 << rf[1:0]) - 32'd1);
      do_op(rs, rwe, rre, rf, ra, {$urandom, $urandom},
            {$urandom, $urandom}, $urandom_range(0, 3),
            $urandom_range(0, 2), got);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
